dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the MIPS core's load/store port and a DMA/loader port. Arbitration is round-robin per transaction. A DMA transaction is a locked burst of 1–16 word accesses with auto-incrementing address. The block sits between the `mips` core and `datamemory` inside `top`. It drives MEMWRITE/dataaddr/writedata, returns readdata to the granted requester, and stalls the core while the DMA port holds the memory.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width
- LEN_W, 4, burst length field width; beats = DMA_LEN+1
- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CPU_REQ  in  1  core requests a memory access this cycle
- CPU_WE  in  1  1 = store, 0 = load
- CPU_ADDR  in  ADDR_W  core byte address
- CPU_WDATA  in  DATA_W  core store data
- CPU_GNT  out  1  core access performed this cycle
- CPU_STALL  out  1  CPU_REQ & ~CPU_GNT
- CPU_RDATA  out  DATA_W  load data, valid when CPU_GNT=1
- DMA_REQ  in  1  DMA requests a burst
- DMA_WE  in  1  burst direction, sampled at grant
- DMA_ADDR  in  ADDR_W  burst base byte address, sampled at grant
- DMA_LEN  in  LEN_W  beats-1, sampled at grant
- DMA_WDATA  in  DATA_W  write data for the current beat
- DMA_GNT  out  1  a DMA beat is performed this cycle
- DMA_RDATA  out  DATA_W  read data for current beat, valid when DMA_GNT=1
- DMA_DONE  out  1  registered one-cycle pulse after last beat
- MEM_WE  out  1  to datamemory MEMWRITE
- MEM_ADDR  out  ADDR_W  to datamemory dataaddr
- MEM_WDATA  out  DATA_W  to datamemory writedata
- MEM_RDATA  in  DATA_W  from datamemory readdata (combinational read)

## Operation
- States: IDLE, BURST. Registers: state, last_owner (0=CPU, 1=DMA), beat counter (LEN_W), remaining count, burst address, burst WE, DMA_DONE.
- IDLE, decision each cycle from the current requests:
  - Only CPU_REQ: grant CPU; last_owner<=CPU.
  - Only DMA_REQ: grant DMA beat 0; last_owner<=DMA.
  - Both: grant the requester that is not last_owner.
  - Neither: no grant, MEM_WE=0.
- CPU grant is a single cycle with no lock. MEM_ADDR=CPU_ADDR, MEM_WE=CPU_WE, MEM_WDATA=CPU_WDATA, CPU_RDATA=MEM_RDATA.
- DMA beat 0 runs in the grant cycle, using DMA_ADDR/DMA_WE live. DMA_LEN, DMA_WE and DMA_ADDR+4 are captured.
  - DMA_LEN=0: stay IDLE and pulse DONE next cycle.
  - DMA_LEN>0: go to BURST.
- BURST: one beat per cycle. MEM_ADDR = captured address, incremented by 4 each beat (mod 2^ADDR_W). MEM_WE = captured WE. MEM_WDATA = DMA_WDATA. DMA_GNT=1 and CPU_GNT=0 every cycle. DMA_REQ is ignored; the burst always completes. After beat LEN, return to IDLE and set DONE for the next cycle.
- The cycle after the last beat is IDLE. If CPU_REQ=1, the CPU wins, because last_owner=DMA.
- Memory write commits at the rising edge that ends the granted cycle. Read data is combinational in the granted cycle.
- MEM_WE is never 1 without a grant. CPU_GNT and DMA_GNT are never both 1.
- Reset (asynchronous, any time, including mid-burst):
  - Registers: state=IDLE, last_owner=DMA, so the CPU wins the first tie. Counters=0, DMA_DONE=0.
  - The aborted burst produces no DONE.
- Reset output values with no requests: all GNT, STALL, MEM_WE, DONE = 0. MEM_ADDR/MEM_WDATA/RDATA outputs = 0.

## Timing
- CPU grant latency: 0 cycles (REQ→GNT combinational) when IDLE and uncontested.
- CPU worst-case stall behind a DMA burst: LEN+1 cycles, max 16.
- DMA burst of N beats occupies exactly N consecutive cycles. DONE is high in cycle N+1, and in that same cycle a new grant may issue.
- Back-to-back DMA bursts with CPU_REQ held: DMA and CPU alternate (CPU access, burst, CPU access, ...).
- The CPU_REQ→CPU_GNT→MEM_* path is combinational; no registers are in the CPU path.

## Test plan
- Reset then CPU only: store 0xDEADBEEF to 0x08, then load 0x08 → CPU_GNT=1 both cycles, CPU_STALL=0, CPU_RDATA=0xDEADBEEF.
- DMA only: write burst LEN=3 at base 0x10, data 1,2,3,4 → MEM_ADDR 0x10,0x14,0x18,0x1C on 4 consecutive cycles, DMA_DONE in cycle 5. A subsequent read burst returns 1..4.
- Contention at first cycle after reset: CPU_REQ and DMA_REQ (LEN=2) both high → CPU granted first. DMA beats on the next 3 cycles; CPU_STALL=1 if it requests during them.
- CPU mid-burst: DMA LEN=15 in progress, CPU_REQ raised at beat 2 → CPU_STALL=1 for beats 2–15. CPU granted the cycle after beat 15, same cycle DMA_DONE=1.
- RESET_N pulled low at beat 1 of a LEN=5 write burst → outputs zero immediately, no DONE pulse, only beats 0 (and 1 if edge occurred) written. Next tie goes to CPU.
- Address wrap: DMA_ADDR=0xFFFFFFFC, LEN=1 → beat addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core's
// load/store port and a DMA port issuing locked, auto-incrementing bursts.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_STALL,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              DMA_REQ,
  input  logic              DMA_WE,
  input  logic [ADDR_W-1:0] DMA_ADDR,
  input  logic [LEN_W-1:0]  DMA_LEN,
  input  logic [DATA_W-1:0] DMA_WDATA,
  output logic              DMA_GNT,
  output logic [DATA_W-1:0] DMA_RDATA,
  output logic              DMA_DONE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t              state_q, state_d;
  logic                last_dma_q, last_dma_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic                bwe_q, bwe_d;
  logic                done_q, done_d;
  logic                cpu_gnt, dma_gnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      last_dma_q <= 1'b1;
      remain_q   <= '0;
      baddr_q    <= '0;
      bwe_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      remain_q   <= remain_d;
      baddr_q    <= baddr_d;
      bwe_q      <= bwe_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    remain_d   = remain_q;
    baddr_d    = baddr_q;
    bwe_d      = bwe_q;
    done_d     = 1'b0;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    MEM_WE     = 1'b0;
    MEM_ADDR   = '0;
    MEM_WDATA  = '0;
    // Grants are suppressed while reset is held so the memory sees no access.
    if (RESET_N) begin
      unique case (state_q)
        ST_IDLE: begin
          if (CPU_REQ && (!DMA_REQ || last_dma_q)) begin
            cpu_gnt    = 1'b1;
            last_dma_d = 1'b0;
            MEM_WE     = CPU_WE;
            MEM_ADDR   = CPU_ADDR;
            MEM_WDATA  = CPU_WDATA;
          end else if (DMA_REQ) begin
            dma_gnt    = 1'b1;
            last_dma_d = 1'b1;
            MEM_WE     = DMA_WE;
            MEM_ADDR   = DMA_ADDR;
            MEM_WDATA  = DMA_WDATA;
            bwe_d      = DMA_WE;
            baddr_d    = DMA_ADDR + ADDR_W'(4);
            remain_d   = DMA_LEN;
            if (DMA_LEN == '0) done_d = 1'b1;
            else               state_d = ST_BURST;
          end
        end
        ST_BURST: begin
          dma_gnt   = 1'b1;
          MEM_WE    = bwe_q;
          MEM_ADDR  = baddr_q;
          MEM_WDATA = DMA_WDATA;
          baddr_d   = baddr_q + ADDR_W'(4);
          remain_d  = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign CPU_GNT   = cpu_gnt;
  assign DMA_GNT   = dma_gnt;
  assign CPU_STALL = CPU_REQ & ~cpu_gnt;
  assign CPU_RDATA = cpu_gnt ? MEM_RDATA : '0;
  assign DMA_RDATA = dma_gnt ? MEM_RDATA : '0;
  assign DMA_DONE  = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model (pending-beat address queue and a reference memory).
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [31:0] CPU_ADDR = '0, CPU_WDATA = '0;
  logic        CPU_GNT, CPU_STALL;
  logic [31:0] CPU_RDATA;
  logic        DMA_REQ = 1'b0, DMA_WE = 1'b0;
  logic [31:0] DMA_ADDR = '0, DMA_WDATA = '0;
  logic [3:0]  DMA_LEN = '0;
  logic        DMA_GNT, DMA_DONE;
  logic [31:0] DMA_RDATA;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_GNT(CPU_GNT), .CPU_STALL(CPU_STALL), .CPU_RDATA(CPU_RDATA),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_LEN(DMA_LEN),
    .DMA_WDATA(DMA_WDATA), .DMA_GNT(DMA_GNT), .DMA_RDATA(DMA_RDATA), .DMA_DONE(DMA_DONE),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // 64-word memory with combinational read, addressed by word index
  logic [31:0] mem [64];
  assign MEM_RDATA = mem[MEM_ADDR[7:2]];
  always @(posedge CLK) if (MEM_WE) mem[MEM_ADDR[7:2]] <= MEM_WDATA;

  // Reference model state
  logic [31:0] ref_mem [64];
  logic [31:0] pend[$];
  bit          m_we, m_last_dma, m_done;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_we = 1'b0;
    m_last_dma = 1'b1;
    m_done = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model
  task automatic step(input bit creq, input bit cwe, input logic [31:0] caddr,
                      input logic [31:0] cwd, input bit dreq, input bit dwe,
                      input logic [31:0] daddr, input logic [3:0] dlen,
                      input logic [31:0] dwd);
    bit e_cg, e_dg, e_we, nd;
    logic [31:0] e_addr, e_wd, e_crd, e_drd, rd;
    @(negedge CLK);
    CPU_REQ = creq; CPU_WE = cwe; CPU_ADDR = caddr; CPU_WDATA = cwd;
    DMA_REQ = dreq; DMA_WE = dwe; DMA_ADDR = daddr; DMA_LEN = dlen; DMA_WDATA = dwd;
    #2;
    e_cg = 0; e_dg = 0; e_we = 0; nd = 0;
    e_addr = '0; e_wd = '0; e_crd = '0; e_drd = '0;
    if (pend.size() > 0) begin
      e_dg = 1; e_addr = pend.pop_front(); e_we = m_we; e_wd = dwd;
      if (pend.size() == 0) nd = 1;
    end else if (creq && (!dreq || m_last_dma)) begin
      e_cg = 1; e_addr = caddr; e_we = cwe; e_wd = cwd; m_last_dma = 0;
    end else if (dreq) begin
      e_dg = 1; e_addr = daddr; e_we = dwe; e_wd = dwd; m_we = dwe; m_last_dma = 1;
      for (int k = 1; k <= int'(dlen); k++) pend.push_back(daddr + 32'(4 * k));
      if (dlen == 0) nd = 1;
    end
    rd = ref_mem[e_addr[7:2]];
    if (e_cg) e_crd = rd;
    if (e_dg) e_drd = rd;
    chk("cpu_gnt",   32'(CPU_GNT),   32'(e_cg));
    chk("dma_gnt",   32'(DMA_GNT),   32'(e_dg));
    chk("cpu_stall", 32'(CPU_STALL), 32'(creq && !e_cg));
    chk("mem_we",    32'(MEM_WE),    32'(e_we));
    chk("mem_addr",  MEM_ADDR,       e_addr);
    chk("mem_wdata", MEM_WDATA,      e_wd);
    chk("cpu_rdata", CPU_RDATA,      e_crd);
    chk("dma_rdata", DMA_RDATA,      e_drd);
    chk("dma_done",  32'(DMA_DONE),  32'(m_done));
    if (e_we) ref_mem[e_addr[7:2]] = e_wd;
    m_done = nd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_cgnt"},  32'(CPU_GNT),   '0);
    chk({tag, "_dgnt"},  32'(DMA_GNT),   '0);
    chk({tag, "_stall"}, 32'(CPU_STALL), '0);
    chk({tag, "_we"},    32'(MEM_WE),    '0);
    chk({tag, "_done"},  32'(DMA_DONE),  '0);
    chk({tag, "_addr"},  MEM_ADDR,       '0);
    chk({tag, "_wdata"}, MEM_WDATA,      '0);
    chk({tag, "_crd"},   CPU_RDATA,      '0);
    chk({tag, "_drd"},   DMA_RDATA,      '0);
  endtask

  // Reset asserted asynchronously mid-cycle, with requests dropped
  task automatic async_reset();
    @(negedge CLK);
    CPU_REQ = 0; DMA_REQ = 0;
    #3 RESET_N = 1'b0;
    #1 chk_zero_outputs("rst");
    model_reset();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    model_reset();
    #12 chk_zero_outputs("por");
    @(negedge CLK);
    RESET_N = 1'b1;

    // CPU only: store then load
    step(1, 1, 32'h08, 32'hDEADBEEF, 0, 0, '0, '0, '0);
    step(1, 0, 32'h08, '0, 0, 0, '0, '0, '0);
    chk("cpu_load_lit", CPU_RDATA, 32'hDEADBEEF);

    // DMA write burst then read burst
    step(0, 0, '0, '0, 1, 1, 32'h10, 4'd3, 32'd1);
    for (int b = 2; b <= 4; b++) step(0, 0, '0, '0, 0, 0, '0, '0, 32'(b));
    step(0, 0, '0, '0, 1, 0, 32'h10, 4'd3, '0);
    chk("rd_beat0_lit", DMA_RDATA, 32'd1);
    for (int b = 2; b <= 4; b++) begin
      step(0, 0, '0, '0, 0, 0, '0, '0, '0);
      chk("rd_beat_lit", DMA_RDATA, 32'(b));
    end
    idle(1);

    // Contention right after reset: CPU wins first, CPU stalls behind burst
    async_reset();
    step(1, 0, 32'h20, '0, 1, 1, 32'h40, 4'd2, 32'hA0);
    step(1, 0, 32'h20, '0, 1, 1, 32'h40, 4'd2, 32'hA0);
    step(1, 0, 32'h20, '0, 0, 0, '0, '0, 32'hA1);
    step(1, 0, 32'h20, '0, 0, 0, '0, '0, 32'hA2);
    step(1, 0, 32'h20, '0, 0, 0, '0, '0, '0);
    idle(1);

    // Long burst, CPU raised at beat 2; CPU granted alongside DONE
    step(0, 0, '0, '0, 1, 1, 32'h80, 4'd15, 32'hB0);
    step(0, 0, '0, '0, 0, 0, '0, '0, 32'hB1);
    for (int b = 2; b <= 15; b++) step(1, 1, 32'h24, 32'hC0, 0, 0, '0, '0, 32'(b));
    step(1, 1, 32'h24, 32'hC0, 1, 0, 32'h30, 4'd0, '0);
    chk("done_with_cpu", 32'(DMA_DONE & CPU_GNT), 32'd1);
    idle(2);

    // Reset at beat 1 of a LEN=5 write burst
    step(0, 0, '0, '0, 1, 1, 32'h50, 4'd5, 32'hE0);
    async_reset();
    step(1, 0, 32'h54, '0, 1, 0, 32'h60, 4'd0, '0);
    chk("beat1_not_written", CPU_RDATA, 32'h1000_0015);
    step(1, 0, 32'h50, '0, 0, 0, '0, '0, '0);
    chk("beat0_written", CPU_RDATA, 32'hE0);
    idle(1);

    // Address wrap
    step(0, 0, '0, '0, 1, 1, 32'hFFFF_FFFC, 4'd1, 32'h77);
    step(0, 0, '0, '0, 0, 0, '0, '0, 32'h78);
    chk("wrap_addr", MEM_ADDR, 32'h0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] dl;
      dl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
           {24'h0, 6'($urandom_range(0, 63)), 2'b00}, dl, $urandom);
      if (i == 1000) async_reset();
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
